s2p_frame_ctrl: RTL
===================

S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, 8'hE4, frame sync pattern; first serial bit received is MSB.
REQ-002 SHALL have parameter PAYLOAD_SYMS, 4, number of 4-bit symbols per frame; legal range 1-255.
REQ-003 SHALL have parameter MISS_LIMIT, 2, consecutive sync misses that drop lock; legal range 1-7.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port srl  input  1  serial data bit.
REQ-007 SHALL have port srl_vld  input  1  srl is sampled only on edges where srl_vld=1.
REQ-008 SHALL have port ParaSig1  output  2  {b0,b2} of the last payload symbol.
REQ-009 SHALL have port ParaSig2  output  2  {b1,b3} of the last payload symbol.
REQ-010 SHALL have port sym_valid  output  1  one-cycle pulse: ParaSig1/ParaSig2 hold a new symbol.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse: the controller has entered PAYLOAD.
REQ-012 SHALL have port locked  output  1  high whenever the state is not HUNT.
REQ-013 SHALL have port sync_err  output  1  one-cycle pulse: sync word mismatch in VERIFY.

Function
REQ-014 SHALL implement states HUNT, PAYLOAD and VERIFY, all driven by registers.
REQ-015 SHALL hold all state, counters and outputs on edges with srl_vld=0; sym_valid, frame_start and sync_err SHALL be 0 on those edges.
REQ-016 SHALL keep an 8-bit shift register that takes srl on every valid bit, in all states.
REQ-017 HUNT: SHALL declare a match on the valid edge where {shift[6:0],srl}==SYNC_WORD and at least 7 valid bits have already arrived since HUNT was entered.
REQ-018 HUNT match: SHALL move to PAYLOAD, clear the bit/symbol counters and pulse frame_start on that edge, so frame_start is visible the next cycle.
REQ-019 PAYLOAD: SHALL group valid bits in arrival order as b0..b3.
REQ-020 On the edge that samples b3, SHALL register ParaSig1={b0,b2} and ParaSig2={b1,b3} and pulse sym_valid; latency is 0 valid bits after b3.
REQ-021 ParaSig1/ParaSig2 SHALL hold their value between symbols and outside PAYLOAD.
REQ-022 On the edge that emits symbol number PAYLOAD_SYMS, SHALL move to VERIFY.
REQ-023 VERIFY: SHALL collect 8 valid bits and compare {shift[6:0],srl} with SYNC_WORD on the 8th bit.
REQ-024 VERIFY match: SHALL clear the miss counter, move to PAYLOAD and pulse frame_start.
REQ-025 VERIFY mismatch: SHALL pulse sync_err and increment the miss counter.
REQ-026 After a mismatch, if the new miss count is less than MISS_LIMIT, SHALL move to PAYLOAD (flywheel) and pulse frame_start.
REQ-027 After a mismatch, if the new miss count equals MISS_LIMIT, SHALL move to HUNT with no frame_start, clear the miss counter and the HUNT fill counter, and deassert locked the next cycle.
REQ-028 SHALL emit no sym_valid in HUNT or VERIFY.
REQ-029 Bits that arrive in HUNT or VERIFY SHALL never be emitted as a symbol.
REQ-030 The symbol counter SHALL cover values up to 255 without wrap-around errors.
REQ-031 The HUNT fill counter SHALL saturate at 7.

Reset
REQ-032 On a clk edge with rst=1, SHALL enter HUNT and clear all counters and the shift register.
REQ-033 On reset, ParaSig1 and ParaSig2 SHALL be set to 2'b00, and sym_valid, frame_start, locked and sync_err to 0.
REQ-034 rst SHALL take priority over srl_vld and apply in any state, including part-way through a symbol or sync word.
REQ-035 The partial symbol or sync word in progress at reset SHALL be discarded.

Verification
REQ-036 Acquire: bits 1,1,1,0,0,1,0,0 with srl_vld=1 -> frame_start pulses once, then locked=1.
REQ-037 Symbol: after acquire, payload bits 1,0,0,1 -> sym_valid pulses once, ParaSig1=2'b10, ParaSig2=2'b01.
REQ-038 Frame: 4 symbols then sync E4 -> no sync_err, a second frame_start, 4 further sym_valid pulses.
REQ-039 Loss of lock: two consecutive verify words of 8'h00 -> sync_err pulses twice, frame_start after the first only, locked=0 after the second.
REQ-040 Gaps and reset: srl_vld=0 for 5 cycles between bits b1 and b2 -> identical symbol values with no extra pulses; rst=1 after b2 -> all outputs 0 and state HUNT, and the next 8 bits must match E4 before any frame_start.

Source files
------------

// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame controller: hunts for a sync word, splits the
// payload into 4-bit symbols and re-verifies sync between frames.
module s2p_frame_ctrl #(
    parameter logic [7:0] SYNC_WORD    = 8'hE4,
    parameter int         PAYLOAD_SYMS = 4,
    parameter int         MISS_LIMIT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srl,
    input  logic       srl_vld,
    output logic [1:0] ParaSig1,
    output logic [1:0] ParaSig2,
    output logic       sym_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        VERIFY
    } state_e;

    localparam logic [7:0] LAST_SYM = 8'(PAYLOAD_SYMS - 1);
    localparam logic [2:0] MISS_MAX = 3'(MISS_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] fill_q,  fill_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] sym_q,   sym_d;
    logic [2:0] miss_q,  miss_d;
    logic [1:0] p1_q,    p1_d;
    logic [1:0] p2_q,    p2_d;
    logic       sv_q,    sv_d;
    logic       fs_q,    fs_d;
    logic       se_q,    se_d;

    logic [7:0] word;
    logic [2:0] miss_inc;

    assign word     = {shift_q[6:0], srl};
    assign miss_inc = miss_q + 3'd1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        fill_d  = fill_q;
        bit_d   = bit_q;
        sym_d   = sym_q;
        miss_d  = miss_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        sv_d    = 1'b0;
        fs_d    = 1'b0;
        se_d    = 1'b0;

        if (srl_vld) begin
            shift_d = word;
            case (state_q)
                HUNT: begin
                    if (fill_q == 3'd7 && word == SYNC_WORD) begin
                        state_d = PAYLOAD;
                        bit_d   = 3'd0;
                        sym_d   = 8'd0;
                        fs_d    = 1'b1;
                    end else if (fill_q != 3'd7) begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                PAYLOAD: begin
                    if (bit_q == 3'd3) begin
                        // b0..b2 are already in shift_q[2:0]; b3 is on srl now
                        p1_d  = {shift_q[2], shift_q[0]};
                        p2_d  = {shift_q[1], srl};
                        sv_d  = 1'b1;
                        bit_d = 3'd0;
                        if (sym_q == LAST_SYM) begin
                            state_d = VERIFY;
                            sym_d   = 8'd0;
                        end else begin
                            sym_d = sym_q + 8'd1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                VERIFY: begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        sym_d = 8'd0;
                        if (word == SYNC_WORD) begin
                            miss_d  = 3'd0;
                            state_d = PAYLOAD;
                            fs_d    = 1'b1;
                        end else begin
                            se_d = 1'b1;
                            if (miss_inc < MISS_MAX) begin
                                miss_d  = miss_inc;
                                state_d = PAYLOAD;
                                fs_d    = 1'b1;
                            end else begin
                                miss_d  = 3'd0;
                                fill_d  = 3'd0;
                                state_d = HUNT;
                            end
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            shift_q <= 8'd0;
            fill_q  <= 3'd0;
            bit_q   <= 3'd0;
            sym_q   <= 8'd0;
            miss_q  <= 3'd0;
            p1_q    <= 2'b00;
            p2_q    <= 2'b00;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            sym_q   <= sym_d;
            miss_q  <= miss_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            sv_q    <= sv_d;
            fs_q    <= fs_d;
            se_q    <= se_d;
        end
    end

    assign ParaSig1    = p1_q;
    assign ParaSig2    = p2_q;
    assign sym_valid   = sv_q;
    assign frame_start = fs_q;
    assign sync_err    = se_q;
    assign locked      = (state_q != HUNT);

endmodule
